// File: rtl/ccd_raw2rgb_pkg.sv
// Shared types, widths and helpers for the raw Bayer to RGB demosaic path.
package ccd_raw2rgb_pkg;

    localparam int PIX_W = 12;
    localparam int CNT_W = 16;

    // Colour of the current sample expressed against an RGGB reference tile.
    typedef enum logic [1:0] {
        PH_R  = 2'b00,
        PH_GR = 2'b01,
        PH_GB = 2'b10,
        PH_B  = 2'b11
    } bayer_phase_t;

    // Floored mean of two samples; the carry bit of the sum keeps it overflow-free.
    function automatic logic [PIX_W-1:0] avg2(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b);
        logic [PIX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PIX_W:1];
    endfunction

endpackage

// File: rtl/ccd_raw2rgb_if.sv
// Pixel bus between capture, the demosaic block and the frame writer.
interface ccd_raw2rgb_if;
    import ccd_raw2rgb_pkg::*;

    logic [PIX_W-1:0] iDATA;
    logic             iDVAL;
    logic [CNT_W-1:0] iX_Cont;
    logic [CNT_W-1:0] iY_Cont;
    logic [PIX_W-1:0] oRed;
    logic [PIX_W-1:0] oGreen;
    logic [PIX_W-1:0] oBlue;
    logic             oDVAL;
    logic [CNT_W-1:0] oX_Cont;
    logic [CNT_W-1:0] oY_Cont;

    modport slave (
        input  iDATA, iDVAL, iX_Cont, iY_Cont,
        output oRed, oGreen, oBlue, oDVAL, oX_Cont, oY_Cont
    );

    modport master (
        output iDATA, iDVAL, iX_Cont, iY_Cont,
        input  oRed, oGreen, oBlue, oDVAL, oX_Cont, oY_Cont
    );

endinterface

// File: rtl/ccd_line_buffer.sv
// One-line sample store: simple dual-port, read-first, registered read (block-RAM friendly).
module ccd_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int WIDTH = 12,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic             clk_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // Read returns the old word even when the same address is written this cycle.
    always_ff @(posedge clk_i) begin
        if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/ccd_raw2rgb.sv
// 2x2-window Bayer demosaic: two-stage pipeline, fixed 2-cycle latency, no backpressure.
module ccd_raw2rgb
    import ccd_raw2rgb_pkg::*;
#(
    parameter int         COLUMN_WIDTH  = 1280,
    parameter logic [1:0] BAYER_PATTERN = 2'b00
)(
    input  logic         iCLK,
    input  logic         iRST,
    ccd_raw2rgb_if.slave bus
);

    localparam int AW = (COLUMN_WIDTH > 1) ? $clog2(COLUMN_WIDTH) : 1;

    logic             inRange;
    logic [PIX_W-1:0] ramData;

    logic             s1Valid_q;
    logic [PIX_W-1:0] cur_q;
    bayer_phase_t     phase_q;
    logic             x0_q, y0_q, inRange_q;
    logic [CNT_W-1:0] s1X_q, s1Y_q;

    logic [PIX_W-1:0] left_q, upleft_q;
    logic [PIX_W-1:0] up, upEff, leftEff, upleftEff;
    logic [PIX_W-1:0] red_d, green_d, blue_d;

    logic             oDVAL_q;
    logic [PIX_W-1:0] red_q, green_q, blue_q;
    logic [CNT_W-1:0] oX_q, oY_q;

    assign inRange = (bus.iX_Cont < CNT_W'(COLUMN_WIDTH));

    ccd_line_buffer #(
        .DEPTH (COLUMN_WIDTH),
        .WIDTH (PIX_W),
        .AW    (AW)
    ) u_lineBuf (
        .clk_i    (iCLK),
        .rdEn_i   (bus.iDVAL),
        .rdAddr_i (bus.iX_Cont[AW-1:0]),
        .rdData_o (ramData),
        .wrEn_i   (bus.iDVAL & inRange),
        .wrAddr_i (bus.iX_Cont[AW-1:0]),
        .wrData_i (bus.iDATA)
    );

    // Stage 1: capture the sample, its colour phase and edge flags alongside the line-buffer read.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1Valid_q <= 1'b0;
            cur_q     <= '0;
            phase_q   <= PH_R;
            x0_q      <= 1'b0;
            y0_q      <= 1'b0;
            inRange_q <= 1'b0;
            s1X_q     <= '0;
            s1Y_q     <= '0;
        end else begin
            s1Valid_q <= bus.iDVAL;
            if (bus.iDVAL) begin
                cur_q     <= bus.iDATA;
                phase_q   <= bayer_phase_t'({bus.iY_Cont[0] ^ BAYER_PATTERN[1],
                                             bus.iX_Cont[0] ^ BAYER_PATTERN[0]});
                x0_q      <= (bus.iX_Cont == '0);
                y0_q      <= (bus.iY_Cont == '0);
                inRange_q <= inRange;
                s1X_q     <= bus.iX_Cont;
                s1Y_q     <= bus.iY_Cont;
            end
        end
    end

    // Columns beyond the buffer have no stored row above, so they read as black.
    assign up = inRange_q ? ramData : '0;

    // Window memory: the previous valid pixel becomes left/upleft; idle cycles leave it untouched.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            left_q   <= '0;
            upleft_q <= '0;
        end else if (s1Valid_q) begin
            left_q   <= cur_q;
            upleft_q <= up;
        end
    end

    // Missing neighbours on the top row and left column are zeroed for this pixel only.
    assign upEff     = y0_q ? '0 : up;
    assign leftEff   = x0_q ? '0 : left_q;
    assign upleftEff = (x0_q | y0_q) ? '0 : upleft_q;

    // Pick R/G/B from the window according to which colour the current sample is.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        case (phase_q)
            PH_R: begin
                red_d   = cur_q;
                blue_d  = upleftEff;
                green_d = avg2(upEff, leftEff);
            end
            PH_GR: begin
                red_d   = leftEff;
                blue_d  = upEff;
                green_d = avg2(cur_q, upleftEff);
            end
            PH_GB: begin
                red_d   = upEff;
                blue_d  = leftEff;
                green_d = avg2(cur_q, upleftEff);
            end
            PH_B: begin
                red_d   = upleftEff;
                blue_d  = cur_q;
                green_d = avg2(upEff, leftEff);
            end
            default: begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
        endcase
    end

    // Stage 2: register the colour result; outputs hold their last pixel while idle.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oDVAL_q <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            oX_q    <= '0;
            oY_q    <= '0;
        end else begin
            oDVAL_q <= s1Valid_q;
            if (s1Valid_q) begin
                red_q   <= red_d;
                green_q <= green_d;
                blue_q  <= blue_d;
                oX_q    <= s1X_q;
                oY_q    <= s1Y_q;
            end
        end
    end

    assign bus.oDVAL   = oDVAL_q;
    assign bus.oRed    = red_q;
    assign bus.oGreen  = green_q;
    assign bus.oBlue   = blue_q;
    assign bus.oX_Cont = oX_q;
    assign bus.oY_Cont = oY_q;

endmodule
